// File: rtl/pipeline_controller.sv
// pipeline_controller: boot sequencing, buffer write-enable gating,
// load-use bubbles, jump flushes, memory-busy freeze and debug counters.
module pipeline_controller #(
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic                  rs1_used_d,
  input  logic                  rs2_used_d,
  input  logic [REG_ADDR_W-1:0] dest_ex,
  input  logic                  mem_read_ex,
  input  logic                  wb_ex,
  input  logic                  jump_occured,
  input  logic                  mem_busy,
  output logic                  boot_active,
  output logic                  boot_word,
  output logic                  pc_load_hi,
  output logic                  pc_load_lo,
  output logic                  pc_write_en,
  output logic                  pc_sel_jump,
  output logic                  fd_write_en,
  output logic                  de_write_en,
  output logic                  em_write_en,
  output logic                  mw_write_en,
  output logic                  fd_flush,
  output logic                  de_flush,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  typedef enum logic [1:0] {BOOT0, BOOT1, RUN} state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_hazard, w_stall_inc, w_flush_inc;

  // r0 is deliberately not excluded: a load to r0 still stalls its consumer.
  assign w_hazard = mem_read_ex & wb_ex &
                    ((rs1_used_d & (rs1_d == dest_ex)) |
                     (rs2_used_d & (rs2_d == dest_ex)));

  // State register; boot always restarts from BOOT0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= BOOT0;
    else        r_state <= w_next;
  end

  // Next state and all control outputs; RUN priority is freeze > jump > hazard > normal.
  always_comb begin
    w_next      = r_state;
    boot_active = 1'b0;
    boot_word   = 1'b0;
    pc_load_hi  = 1'b0;
    pc_load_lo  = 1'b0;
    pc_write_en = 1'b0;
    pc_sel_jump = 1'b0;
    fd_write_en = 1'b0;
    de_write_en = 1'b0;
    em_write_en = 1'b0;
    mw_write_en = 1'b0;
    fd_flush    = 1'b0;
    de_flush    = 1'b0;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    case (r_state)
      BOOT0: begin
        boot_active = 1'b1;
        pc_load_hi  = 1'b1;
        fd_flush    = 1'b1;
        de_flush    = 1'b1;
        w_next      = BOOT1;
      end
      BOOT1: begin
        boot_active = 1'b1;
        boot_word   = 1'b1;
        pc_load_lo  = 1'b1;
        fd_flush    = 1'b1;
        de_flush    = 1'b1;
        w_next      = RUN;
      end
      RUN: begin
        if (mem_busy) begin
          // Freeze: everything holds; a pending jump is taken once busy drops.
        end else if (jump_occured) begin
          // Jump beats a hazard since the decode instruction is squashed anyway.
          pc_write_en = 1'b1;
          pc_sel_jump = 1'b1;
          fd_write_en = 1'b1;
          de_write_en = 1'b1;
          em_write_en = 1'b1;
          mw_write_en = 1'b1;
          fd_flush    = 1'b1;
          de_flush    = 1'b1;
          w_flush_inc = 1'b1;
        end else if (w_hazard) begin
          // Hold PC and fetch/decode buffer, push a bubble into ALU stage.
          de_write_en = 1'b1;
          em_write_en = 1'b1;
          mw_write_en = 1'b1;
          de_flush    = 1'b1;
          w_stall_inc = 1'b1;
        end else begin
          pc_write_en = 1'b1;
          fd_write_en = 1'b1;
          de_write_en = 1'b1;
          em_write_en = 1'b1;
          mw_write_en = 1'b1;
        end
      end
      default: w_next = BOOT0;
    endcase
  end

  // Saturating event counters for debug.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}})) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_count = r_stall_cnt;
  assign flush_count = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_controller.sv
module tb_pipeline_controller;

  localparam int RW = 3;
  localparam int CW = 16;

  // Output bundle order: ba,bw,lh,ll,pwe,psj,fdw,dew,emw,mww,fdf,def
  localparam logic [11:0] O_BOOT0  = 12'b1010_0000_0011;
  localparam logic [11:0] O_BOOT1  = 12'b1101_0000_0011;
  localparam logic [11:0] O_NORMAL = 12'b0000_1011_1100;
  localparam logic [11:0] O_STALL  = 12'b0000_0001_1101;
  localparam logic [11:0] O_JUMP   = 12'b0000_1111_1111;
  localparam logic [11:0] O_FREEZE = 12'b0000_0000_0000;

  logic clk = 1'b0, reset = 1'b0;
  logic [RW-1:0] rs1_d, rs2_d, dest_ex;
  logic rs1_used_d, rs2_used_d, mem_read_ex, wb_ex, jump_occured, mem_busy;
  logic boot_active, boot_word, pc_load_hi, pc_load_lo, pc_write_en, pc_sel_jump;
  logic fd_write_en, de_write_en, em_write_en, mw_write_en, fd_flush, de_flush;
  logic [CW-1:0] stall_count, flush_count;

  always #5 clk = ~clk;

  pipeline_controller #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d),
    .dest_ex(dest_ex), .mem_read_ex(mem_read_ex), .wb_ex(wb_ex),
    .jump_occured(jump_occured), .mem_busy(mem_busy),
    .boot_active(boot_active), .boot_word(boot_word),
    .pc_load_hi(pc_load_hi), .pc_load_lo(pc_load_lo),
    .pc_write_en(pc_write_en), .pc_sel_jump(pc_sel_jump),
    .fd_write_en(fd_write_en), .de_write_en(de_write_en),
    .em_write_en(em_write_en), .mw_write_en(mw_write_en),
    .fd_flush(fd_flush), .de_flush(de_flush),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  wire [11:0] outs = {boot_active, boot_word, pc_load_hi, pc_load_lo, pc_write_en,
                      pc_sel_jump, fd_write_en, de_write_en, em_write_en, mw_write_en,
                      fd_flush, de_flush};

  typedef struct packed {
    logic [RW-1:0] rs1, rs2, dest;
    logic u1, u2, mr, wb, jmp, busy;
    logic [11:0]   exp_o;
    logic [CW-1:0] exp_s, exp_f;
  } vec_t;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    rs1_d = v.rs1; rs2_d = v.rs2; dest_ex = v.dest;
    rs1_used_d = v.u1; rs2_used_d = v.u2; mem_read_ex = v.mr; wb_ex = v.wb;
    jump_occured = v.jmp; mem_busy = v.busy;
  endtask

  vec_t vecs[12];
  vec_t v;

  initial begin
    //            rs1   rs2   dest  u1 u2 mr wb j  b  outputs   stall  flush
    vecs[0]  = '{3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, O_NORMAL, 16'd0, 16'd0};
    vecs[1]  = '{3'd0, 3'd3, 3'd3, 0, 1, 1, 1, 0, 0, O_STALL,  16'd1, 16'd0};
    vecs[2]  = '{3'd0, 3'd3, 3'd3, 0, 0, 1, 1, 0, 0, O_NORMAL, 16'd1, 16'd0};
    vecs[3]  = '{3'd0, 3'd3, 3'd3, 0, 1, 1, 0, 0, 0, O_NORMAL, 16'd1, 16'd0};
    vecs[4]  = '{3'd5, 3'd1, 3'd5, 1, 0, 1, 1, 0, 0, O_STALL,  16'd2, 16'd0};
    vecs[5]  = '{3'd5, 3'd1, 3'd5, 1, 0, 0, 1, 0, 0, O_NORMAL, 16'd2, 16'd0};
    vecs[6]  = '{3'd4, 3'd1, 3'd5, 1, 1, 1, 1, 0, 0, O_NORMAL, 16'd2, 16'd0};
    vecs[7]  = '{3'd0, 3'd6, 3'd0, 1, 0, 1, 1, 0, 0, O_STALL,  16'd3, 16'd0};
    vecs[8]  = '{3'd0, 3'd3, 3'd3, 0, 1, 1, 1, 1, 0, O_JUMP,   16'd3, 16'd1};
    vecs[9]  = '{3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 1, 0, O_JUMP,   16'd3, 16'd2};
    vecs[10] = '{3'd0, 3'd3, 3'd3, 0, 1, 1, 1, 0, 1, O_FREEZE, 16'd3, 16'd2};
    vecs[11] = '{3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 1, 1, O_FREEZE, 16'd3, 16'd2};

    // Reset state
    drive(vecs[0]);
    #2;
    check("reset_outs", {20'd0, outs}, {20'd0, O_BOOT0});
    check("reset_cnts", {stall_count, flush_count}, 32'd0);

    // Boot sequence
    @(negedge clk); reset = 1'b1;
    #1 check("boot0_outs", {20'd0, outs}, {20'd0, O_BOOT0});
    @(negedge clk); #1 check("boot1_outs", {20'd0, outs}, {20'd0, O_BOOT1});
    @(negedge clk); #1 check("run1_outs", {20'd0, outs}, {20'd0, O_NORMAL});

    // Table-driven RUN vectors
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1 check($sformatf("vec%0d_outs", i), {20'd0, outs}, {20'd0, vecs[i].exp_o});
      @(posedge clk);
      #1 check($sformatf("vec%0d_cnts", i), {stall_count, flush_count},
               {vecs[i].exp_s, vecs[i].exp_f});
    end

    // Freeze for 3 cycles with jump pending, then jump taken once
    v = vecs[11];
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); drive(v);
      #1 check($sformatf("freeze%0d_outs", c), {20'd0, outs}, {20'd0, O_FREEZE});
    end
    @(negedge clk);
    check("freeze_flush_hold", {16'd0, flush_count}, 32'd2);
    v.busy = 1'b0; drive(v);
    #1 check("post_freeze_jump", {20'd0, outs}, {20'd0, O_JUMP});
    @(negedge clk);
    v = vecs[0]; drive(v);
    check("post_freeze_cnts", {stall_count, flush_count}, {16'd3, 16'd3});

    // Drive stall_count up to saturation (currently 3)
    v = vecs[1]; drive(v);
    repeat (65532) @(posedge clk);
    @(negedge clk);
    check("stall_at_max", {16'd0, stall_count}, 32'h0000_FFFF);
    #1 check("stall_outs_at_max", {20'd0, outs}, {20'd0, O_STALL});
    @(posedge clk); #1;
    check("stall_saturated", {16'd0, stall_count}, 32'h0000_FFFF);

    // Reset asserted mid-stall clears immediately, without a clock edge
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    check("midstall_reset_outs", {20'd0, outs}, {20'd0, O_BOOT0});
    check("midstall_reset_cnts", {stall_count, flush_count}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Central sequencing and hazard controller for the five-stage pipelined processor (fetch, decode, ALU, memory, write-back). After reset it loads the 32-bit start PC from instruction memory words 0 and 1. It then gates every pipeline-buffer write enable, inserts load-use bubbles, and flushes wrong-path instructions on a taken jump. It freezes the whole pipeline while data memory reports busy, and keeps saturating stall and flush event counters for debug.

## Interface
- REG_ADDR_W, 3, register-file address width
- CNT_W, 16, width of the stall_count and flush_count counters
- clk  input  1  pipeline clock, all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- rs1_d, rs2_d  input  REG_ADDR_W each  source registers of the instruction in decode
- rs1_used_d, rs2_used_d  input  1 each  the matching source is actually read
- dest_ex  input  REG_ADDR_W  destination register of the instruction in the ALU stage
- mem_read_ex, wb_ex  input  1 each  the ALU-stage instruction is a load / writes back
- jump_occured  input  1  taken jump resolved in the ALU stage this cycle
- mem_busy  input  1  data memory cannot complete its access this cycle
- boot_active  output  1  fetch address comes from boot_word, not from the PC
- boot_word  output  1  instruction-memory word address used during boot (0 or 1)
- pc_load_hi, pc_load_lo  output  1 each  load PC[31:16] / PC[15:0] from the fetched word
- pc_write_en  output  1  PC advances, or takes the jump target
- pc_sel_jump  output  1  PC next value is the jump target
- fd_write_en, de_write_en, em_write_en, mw_write_en  output  1 each  buffer write enables
- fd_flush, de_flush  output  1 each  synchronously clear the buffer into a no-op bubble
- stall_count, flush_count  output  CNT_W each  saturating event counters

## Operation
- FSM states: BOOT0, BOOT1, RUN. The reset value of the state register is BOOT0.
- Outputs are combinational from the state and the inputs. The counters are registers.
- BOOT0 outputs: boot_active=1, boot_word=0, pc_load_hi=1.
- BOOT1 outputs: boot_active=1, boot_word=1, pc_load_lo=1.
- In both boot states all write enables are 0 and fd_flush=de_flush=1.
- Boot transitions: BOOT0 -> BOOT1 -> RUN, unconditionally, one cycle each.
- Reset output values (state BOOT0): boot_active=1, boot_word=0, pc_load_hi=1, pc_load_lo=0, all write enables 0, pc_sel_jump=0, fd_flush=1, de_flush=1, stall_count=0, flush_count=0.
- RUN uses a fixed priority; the first matching case wins.
  - Freeze (mem_busy=1): all write enables 0, no flush, pc_sel_jump=0, counters hold. A jump_occured during freeze is ignored; it stays asserted and is acted on when mem_busy falls.
  - Jump (jump_occured=1): pc_write_en=1, pc_sel_jump=1, fd_flush=1, de_flush=1, all write enables 1. flush_count increments.
  - Load-use hazard (mem_read_ex & wb_ex & ((rs1_used_d & rs1_d==dest_ex) | (rs2_used_d & rs2_d==dest_ex))): pc_write_en=0, fd_write_en=0, de_flush=1, de_write_en=em_write_en=mw_write_en=1. stall_count increments.
  - Normal: all write enables 1, no flush, pc_sel_jump=0.
- A jump wins over a simultaneous load-use hazard, because the decode instruction is squashed anyway. Only flush_count increments in that cycle.
- Counters saturate at all-ones and never wrap.
- Reset asserted in any state, including mid-stall: the state and counters return to their reset values immediately (asynchronously).
- Register r0 is not special-cased. A load to any register, including r0, triggers the stall.

## Timing
- Boot takes exactly 2 cycles after reset deasserts. The first RUN cycle is the third rising edge after reset release.
- A load-use stall lasts exactly 1 cycle. The bubble moves the load onward, so the hazard clears on the next cycle unless a new load is in the ALU stage.
- The jump penalty is 2 squashed instructions. The redirect and the flush happen in the same cycle as jump_occured.
- Freeze has no latency: the enables drop in the same cycle mem_busy rises and recover in the cycle it falls.
- Counter updates become visible one cycle after the event.

## Test plan
- Release reset, no other activity -> BOOT0: pc_load_hi=1, boot_word=0. BOOT1: pc_load_lo=1, boot_word=1. Cycle 3: all write enables=1, no flush.
- In RUN: dest_ex=3, mem_read_ex=1, wb_ex=1, rs2_d=3, rs2_used_d=1 -> one cycle with pc_write_en=0, fd_write_en=0, de_flush=1; stall_count goes 0->1.
- Same as the previous case with rs2_used_d=0 -> no stall. Same with wb_ex=0 -> no stall.
- jump_occured=1 together with a load-use hazard -> pc_sel_jump=1, fd_flush=de_flush=1, pc_write_en=1; flush_count=1, stall_count unchanged.
- mem_busy=1 for 3 cycles while jump_occured=1 -> all enables 0 for 3 cycles, then one jump cycle; flush_count increments once.
- Force stall_count to 0xFFFF via 65535 stalls, then one more stall -> stays 0xFFFF. Assert reset mid-stall -> state BOOT0, both counters 0 immediately.
